// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared types and glyph constants for the 7-segment scanner
// Rev 1.0
// ============================================================================
`default_nettype none

package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; the dp bit is added by the decoder.
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

`default_nettype wire

// File: rtl/seg_decoder.sv
// ============================================================================
// seg_decoder : combinational hex nibble + dp + blank -> active-low segments
// Rev 1.0
// ============================================================================
`default_nettype none

module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] segments_n
);

  logic [6:0] glyph;

  always_comb begin
    glyph = GLYPH_0;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = GLYPH_0;
    endcase
    // A suppressed digit keeps its decimal point.
    segments_n = {~dp, blank ? SEG_OFF[6:0] : glyph};
  end

endmodule

`default_nettype wire

// File: rtl/digit_scanner.sv
// ============================================================================
// digit_scanner : 4-digit 7-segment scan engine with frame-aligned updates
// Rev 1.0
// ============================================================================
`default_nettype none

module digit_scanner
  import display_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 2000,
  parameter int BLANK_TICKS     = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        lz_blank_en,
  output logic [1:0]  digitCount,
  output logic [7:0]  segments_n,
  output logic        digit_enable,
  output logic        frame_done
);

  localparam int TICK_MAX = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [TICK_W-1:0] SHOW_LAST  = TICK_W'(TICKS_PER_DIGIT - 1);
  localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);

  scan_state_t       state, state_next;
  logic [TICK_W-1:0] tick, tick_next;
  logic              digit_last;
  logic              frame_end;
  logic              frame_next;

  logic [15:0] disp_value, pend_value;
  logic [3:0]  disp_dp, pend_dp;
  logic        pending_full;
  logic        accept;

  logic [NUM_DIGITS-2:0] nib_zero;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  blank_digit;
  logic [7:0]            dec_seg;

  assign value_ready = !pending_full;
  assign accept      = value_valid && !pending_full;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= BLANK;
      tick  <= '0;
    end else begin
      state <= state_next;
      tick  <= tick_next;
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick + 1'b1;
    digit_last = 1'b0;
    case (state)
      BLANK: begin
        if (tick == BLANK_LAST) begin
          state_next = SHOW;
          tick_next  = '0;
        end
      end
      SHOW: begin
        if (tick == SHOW_LAST) begin
          state_next = BLANK;
          tick_next  = '0;
          digit_last = 1'b1;
        end
      end
      default: begin
        state_next = BLANK;
        tick_next  = '0;
      end
    endcase
    frame_end = digit_last && (digitCount == 2'd3);
    // frame_done is registered, so it is predicted one cycle ahead to
    // coincide with the last SHOW tick of digit 3.
    frame_next = (state_next == SHOW) && (tick_next == SHOW_LAST) && (digitCount == 2'd3);
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      nib_zero[i] = (disp_value[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
    end
    cur_nibble  = disp_value[15:12];
    cur_dp      = disp_dp[3];
    blank_digit = 1'b0;
    case (digitCount)
      2'd0: begin
        cur_nibble  = disp_value[15:12];
        cur_dp      = disp_dp[3];
        blank_digit = nib_zero[0];
      end
      2'd1: begin
        cur_nibble  = disp_value[11:8];
        cur_dp      = disp_dp[2];
        blank_digit = nib_zero[0] && nib_zero[1];
      end
      2'd2: begin
        cur_nibble  = disp_value[7:4];
        cur_dp      = disp_dp[1];
        blank_digit = &nib_zero;
      end
      default: begin
        cur_nibble  = disp_value[3:0];
        cur_dp      = disp_dp[0];
        blank_digit = 1'b0;
      end
    endcase
    blank_digit = blank_digit && lz_blank_en;
  end

  seg_decoder u_seg_decoder (
    .nibble     (cur_nibble),
    .dp         (cur_dp),
    .blank      (blank_digit),
    .segments_n (dec_seg)
  );

  // Outputs are driven from next-state so they change on the state edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digitCount   <= 2'd0;
      segments_n   <= SEG_OFF;
      digit_enable <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      digit_enable <= (state_next == SHOW);
      segments_n   <= (state_next == SHOW) ? dec_seg : SEG_OFF;
      frame_done   <= frame_next;
      if (digit_last) begin
        digitCount <= digitCount + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      disp_value   <= '0;
      disp_dp      <= '0;
      pend_value   <= '0;
      pend_dp      <= '0;
      pending_full <= 1'b0;
    end else begin
      if (frame_end && pending_full) begin
        disp_value   <= pend_value;
        disp_dp      <= pend_dp;
        pending_full <= 1'b0;
      end
      // Accept only happens with pending empty, so it never collides with a copy.
      if (accept) begin
        pend_value   <= value_in;
        pend_dp      <= dp_in;
        pending_full <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_digit_scanner.sv
// ============================================================================
// tb_digit_scanner : directed self-checking bench for digit_scanner
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_digit_scanner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        value_valid;
  logic        value_ready;
  logic        lz_blank_en;
  logic [1:0]  digitCount;
  logic [7:0]  segments_n;
  logic        digit_enable;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  digit_scanner #(
    .TICKS_PER_DIGIT (4),
    .BLANK_TICKS     (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .value_in     (value_in),
    .dp_in        (dp_in),
    .value_valid  (value_valid),
    .value_ready  (value_ready),
    .lz_blank_en  (lz_blank_en),
    .digitCount   (digitCount),
    .segments_n   (segments_n),
    .digit_enable (digit_enable),
    .frame_done   (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Walks one digit period. 'pre' BLANK cycles have already been stepped.
  task automatic check_digit(input string tag, input int d, input logic [7:0] exp, input int pre);
    for (int i = pre; i < 2; i++) begin
      step();
      check({tag, "_blank_seg"}, segments_n, 8'hFF);
      check({tag, "_blank_en"}, digit_enable, 1'b0);
    end
    step();
    check({tag, "_seg"}, segments_n, exp);
    check({tag, "_en"}, digit_enable, 1'b1);
    check({tag, "_dcnt"}, digitCount, d);
    for (int i = 1; i < 4; i++) step();
    check({tag, "_seg_hold"}, segments_n, exp);
    check({tag, "_fdone"}, frame_done, (d == 3) ? 1 : 0);
  endtask

  initial begin
    int n;
    reset_n     = 1'b0;
    value_in    = 16'h0;
    dp_in       = 4'h0;
    value_valid = 1'b0;
    lz_blank_en = 1'b0;
    step();
    step();
    check("rst_seg", segments_n, 8'hFF);
    check("rst_en", digit_enable, 1'b0);
    check("rst_fdone", frame_done, 1'b0);
    check("rst_dcnt", digitCount, 2'd0);
    check("rst_ready", value_ready, 1'b1);

    // Scan timing out of reset
    reset_n = 1'b1;
    check_digit("t1_d0", 0, 8'hC0, 1);
    check_digit("t1_d1", 1, 8'hC0, 0);
    check_digit("t1_d2", 2, 8'hC0, 0);
    check_digit("t1_d3", 3, 8'hC0, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 40);
    check("t1_frame_period", n, 24);

    // Single value accepted while idle
    value_in    = 16'h1234;
    dp_in       = 4'b0010;
    value_valid = 1'b1;
    check("t2_ready_idle", value_ready, 1'b1);
    step();
    value_valid = 1'b0;
    check("t2_ready_full", value_ready, 1'b0);
    check_digit("t2_old_d0", 0, 8'hC0, 1);
    check_digit("t2_old_d1", 1, 8'hC0, 0);
    check_digit("t2_old_d2", 2, 8'hC0, 0);
    check_digit("t2_old_d3", 3, 8'hC0, 0);
    check_digit("t2_d0", 0, 8'hF9, 0);
    check("t2_ready_after", value_ready, 1'b1);
    check_digit("t2_d1", 1, 8'hA4, 0);
    check_digit("t2_d2", 2, 8'h30, 0);
    check_digit("t2_d3", 3, 8'h99, 0);

    // Back-to-back offers with a held producer
    step();
    value_in    = 16'h0000;
    dp_in       = 4'b0000;
    value_valid = 1'b1;
    step();
    value_in = 16'h5678;
    dp_in    = 4'b1000;
    check("t3_ready_busy", value_ready, 1'b0);
    check_digit("t3_cur_d0", 0, 8'hF9, 2);
    check_digit("t3_cur_d1", 1, 8'hA4, 0);
    check_digit("t3_cur_d2", 2, 8'h30, 0);
    check_digit("t3_cur_d3", 3, 8'h99, 0);
    check("t3_ready_at_fe", value_ready, 1'b0);
    step();
    check("t3_ready_freed", value_ready, 1'b1);
    step();
    value_valid = 1'b0;
    check("t3_ready_second", value_ready, 1'b0);
    check_digit("t3_z_d0", 0, 8'hC0, 2);
    check_digit("t3_z_d1", 1, 8'hC0, 0);
    check_digit("t3_z_d2", 2, 8'hC0, 0);
    check_digit("t3_z_d3", 3, 8'hC0, 0);
    check_digit("t3_n_d0", 0, 8'h12, 0);
    check_digit("t3_n_d1", 1, 8'h82, 0);
    check_digit("t3_n_d2", 2, 8'hF8, 0);
    check_digit("t3_n_d3", 3, 8'h80, 0);

    // Accept in the frame_done cycle, then leading-zero suppression
    lz_blank_en = 1'b1;
    value_in    = 16'h0070;
    dp_in       = 4'b0100;
    value_valid = 1'b1;
    check("t5_ready_fe", value_ready, 1'b1);
    step();
    value_valid = 1'b0;
    check("t5_ready_full", value_ready, 1'b0);
    check_digit("t5_keep_d0", 0, 8'h12, 1);
    check_digit("t5_keep_d1", 1, 8'h82, 0);
    check_digit("t5_keep_d2", 2, 8'hF8, 0);
    check_digit("t5_keep_d3", 3, 8'h80, 0);
    step();
    check("t4_ready_freed", value_ready, 1'b1);
    value_in    = 16'h0000;
    dp_in       = 4'b0000;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    check_digit("t4_lz_d0", 0, 8'hFF, 2);
    check_digit("t4_lz_d1", 1, 8'h7F, 0);
    check_digit("t4_lz_d2", 2, 8'hF8, 0);
    check_digit("t4_lz_d3", 3, 8'hC0, 0);
    check_digit("t4_zero_d0", 0, 8'hFF, 0);
    check_digit("t4_zero_d1", 1, 8'hFF, 0);
    check_digit("t4_zero_d2", 2, 8'hFF, 0);
    check_digit("t4_zero_d3", 3, 8'hC0, 0);

    // Reset mid-SHOW of digit 2 with pending full
    step();
    value_in    = 16'h9999;
    dp_in       = 4'hF;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    check("t6_ready_full", value_ready, 1'b0);
    check_digit("t6_d0", 0, 8'hFF, 2);
    check_digit("t6_d1", 1, 8'hFF, 0);
    step();
    step();
    step();
    check("t6_d2_en", digit_enable, 1'b1);
    check("t6_d2_dcnt", digitCount, 2'd2);
    step();
    reset_n = 1'b0;
    step();
    check("t6_rst_seg", segments_n, 8'hFF);
    check("t6_rst_en", digit_enable, 1'b0);
    check("t6_rst_fdone", frame_done, 1'b0);
    check("t6_rst_dcnt", digitCount, 2'd0);
    check("t6_rst_ready", value_ready, 1'b1);
    reset_n     = 1'b1;
    lz_blank_en = 1'b0;
    check_digit("t6_post_d0", 0, 8'hC0, 1);
    check_digit("t6_post_d1", 1, 8'hC0, 0);
    check_digit("t6_post_d2", 2, 8'hC0, 0);
    check_digit("t6_post_d3", 3, 8'hC0, 0);
    check_digit("t6_next_d0", 0, 8'hC0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/digit_scanner.md
# digit_scanner

Time-multiplexed scan engine for the 4-digit 7-segment display. Holds a 4-nibble display value and steps the digit index through MSB to LSB at a programmable rate. For each digit it drives the segment pattern, the decimal point and a digit enable, with a blanking gap between digits to suppress ghosting. Its `digitCount` output feeds the digit-select translator directly. New values are accepted through a valid/ready handshake and applied only at a frame boundary, so no partial update is ever displayed.

## Interface
Parameters:
- `TICKS_PER_DIGIT`, 2000: clk cycles a digit is lit (SHOW); ≥1.
- `BLANK_TICKS`, 100: clk cycles all segments are off before each digit (BLANK); ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `value_in`  in  16  four hex nibbles; [15:12] is the MSB digit, [3:0] is the LSB digit.
- `dp_in`  in  4  decimal points; bit 3 is the MSB digit.
- `value_valid`  in  1  `value_in`/`dp_in` offered.
- `value_ready`  out  1  pending slot empty; transfer occurs on `value_valid & value_ready`.
- `lz_blank_en`  in  1  enables leading-zero suppression.
- `digitCount`  out  2  current digit index: 0 is MSB, 3 is LSB.
- `segments_n`  out  8  active-low {dp,g,f,e,d,c,b,a}.
- `digit_enable`  out  1  high only in SHOW.
- `frame_done`  out  1  one-cycle pulse at the end of the digit-3 SHOW.

## Operation
- Registers:
  - display register (16+4 bits);
  - pending register (16+4) plus `pending_full`;
  - tick counter, width `$clog2(max(TICKS_PER_DIGIT,BLANK_TICKS))`;
  - 2-bit `digitCount`;
  - FSM state.
- FSM states:
  - BLANK: tick counter runs 0..BLANK_TICKS-1, then go to SHOW with the counter cleared.
  - SHOW: tick counter runs 0..TICKS_PER_DIGIT-1. At the last tick:
    - `digitCount` increments, wrapping 3→0;
    - state goes to BLANK with the counter cleared;
    - if `digitCount` was 3, this is the frame end.
- Frame end, same cycle as the last SHOW tick of digit 3:
  - `frame_done`=1 for that cycle;
  - if `pending_full`, the pending register copies into the display register and `pending_full` clears.
- Handshake:
  - `value_ready` = !`pending_full`, combinational from the register.
  - An accepted value sets `pending_full` and loads the pending register.
  - `value_valid` while `value_ready`=0 is ignored; the producer must hold the value.
  - Accept and frame end in the same cycle: only possible with pending empty. The new value lands in pending and is applied at the following frame end.
- Leading-zero suppression: digit i (i<3) is blanked when `lz_blank_en`=1 and display nibbles 0..i are all zero.
  - Digit 3 is never suppressed.
  - A blanked digit still drives its DP from `dp_in`.
  - `digit_enable` follows the normal SHOW timing for a blanked digit.
- Segment decode: full hex, 0–F. Glyphs follow the team's standard pattern table.
- Reset mid-operation: state and all outputs return to their reset values on the next edge. Pending and display contents are cleared.

## Timing
- Reset values:
  - `digitCount`=0;
  - `segments_n`=8'hFF;
  - `digit_enable`=0;
  - `frame_done`=0;
  - `value_ready`=1;
  - display=0, pending empty;
  - state BLANK with the tick counter at 0.
- All outputs are registered except `value_ready`.
- During BLANK, `segments_n`=8'hFF.
- `segments_n` and `digit_enable` update on the same edge as the state change, so there is zero skew between them.
- `digitCount` changes only on the SHOW→BLANK edge, which gives a full BLANK period of settling for the downstream translator.
- Digit period = BLANK_TICKS+TICKS_PER_DIGIT cycles; frame = 4× the digit period.
- Accept-to-display latency: at most one frame plus one digit period.
- First SHOW after reset begins at cycle BLANK_TICKS.

## Structure
- Package `display_pkg` holds:
  - `NUM_DIGITS`=4;
  - the `scan_state_t` enum {BLANK, SHOW};
  - the `SEG_OFF`=8'hFF constant;
  - the hex-to-segment glyph constants.
- One sub-module, `seg_decoder`: combinational, 4-bit nibble + dp + blank → `segments_n`. It is instantiated once and registered in `digit_scanner`.

## Test plan
Benches use `TICKS_PER_DIGIT`=4 and `BLANK_TICKS`=2.

1. Reset release → `segments_n`=8'hFF, `digit_enable`=0 for 2 cycles. `digit_enable` then high for 4 cycles. `digitCount` sequence 0,1,2,3,0 with a 6-cycle period. `frame_done` pulses every 24 cycles.
2. Offer 16'h1234 with dp 4'b0010 while idle → accepted in 1 cycle. After the next `frame_done`, digits show "1","2","3","4" with the DP lit only during digit 2.
3. Offer 16'h0000, hold `value_valid`, then offer 16'h5678 → `value_ready`=0 until the frame end. The second value is applied one frame later and the first is never corrupted.
4. `lz_blank_en`=1 with value 16'h0070 → digits 0–1 blank (8'hFF plus DP from `dp_in`), digit 2 shows "7", digit 3 shows "0". With value 0 only digit 3 shows "0".
5. Accept in the exact `frame_done` cycle with pending empty → the value appears at the next frame end, not the current one.
6. Assert `reset_n`=0 mid-SHOW of digit 2 with pending full → next edge: all reset values, `value_ready`=1, display=0.
